// File: rtl/count_pwm.sv
// ---------------------------------------------------------------------------
// count_pwm
//
// Turns a free-running count from an upstream up-counter into a registered
// PWM waveform.  A new duty threshold is accepted through a valid/ready
// handshake into a one-deep shadow register.  The shadow is copied to the
// active duty only when the count wraps (MAX -> MIN), so every period runs
// with a single, consistent threshold.
//
// Parameters
//   MAX  largest value the incoming count reaches; W = $clog2(MAX+1)
//   MIN  count value at which each period starts
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   count[W-1:0] upstream count, MIN..MAX, wrapping MAX -> MIN
//   pwm_en       output enable; 0 forces pwm_out low
//   duty[W:0]    requested threshold; any value above MAX means always-high
//   duty_valid   duty carries a new value
//   duty_ready   block can accept a new duty (shadow register is empty)
//   pwm_out      registered PWM waveform, one cycle behind count
//   period_done  one-cycle pulse, the cycle after each detected wrap
//
// Optional feature (macro COUNT_PWM_IRQ_EN)
//   irq_clr      clears irq
//   irq          sticky interrupt, set by period_done, cleared by irq_clr;
//                a set and a clear in the same cycle leave irq set
// ---------------------------------------------------------------------------
module count_pwm #(
    parameter int MAX = 255,
    parameter int MIN = 0,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] count,
    input  logic         pwm_en,
    input  logic [W:0]   duty,
    input  logic         duty_valid,
`ifdef COUNT_PWM_IRQ_EN
    input  logic         irq_clr,
    output logic         irq,
`endif
    output logic         duty_ready,
    output logic         pwm_out,
    output logic         period_done
);

    // A period must contain at least two count values for a wrap to exist.
    if (MIN >= MAX) begin : g_range_check
        $error("count_pwm: MIN must be smaller than MAX");
    end

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   count_q;
    logic [W:0]     shadow_q;
    logic [W:0]     shadow_d;
    logic [W:0]     duty_active_q;
    logic [W:0]     duty_active_d;
    logic [W:0]     duty_eff;
    logic           wrap;
    logic           transfer;

    // Unsigned threshold test with the count zero-extended, so a threshold
    // of MAX+1 or more is above every possible count.
    function automatic logic duty_hit(input logic [W-1:0] c,
                                      input logic [W:0]   thr);
        return ({1'b0, c} < thr);
    endfunction

    // A wrap is the only way the upstream counter can go backwards.  A held
    // count (upstream stalled or prescaled) never looks like a wrap.
    assign wrap = (count < count_q);

    // Update FSM: next state, shadow/active duty and the duty in use this
    // cycle.  On a wrap while PENDING the shadow is used directly, so the new
    // duty governs the very first count of the new period.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        duty_active_d = duty_active_q;
        duty_eff      = duty_active_q;
        duty_ready    = 1'b0;
        transfer      = 1'b0;

        case (state_q)
            EMPTY: begin
                duty_ready = 1'b1;
                transfer   = duty_valid;
                // A transfer coinciding with a wrap is held for the next
                // wrap: the current period has already started.
                if (transfer) begin
                    shadow_d = duty;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                // duty_valid is ignored here; the shadow stays intact until
                // it has been applied.
                if (wrap) begin
                    duty_eff      = shadow_q;
                    duty_active_d = shadow_q;
                    state_d       = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Stage boundary: count sample, FSM, duty registers and outputs.
    // count_q resets to MAX so a post-reset count of MAX is not a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            count_q       <= W'(MAX);
            shadow_q      <= '0;
            duty_active_q <= '0;
            pwm_out       <= 1'b0;
            period_done   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count;
            shadow_q      <= shadow_d;
            duty_active_q <= duty_active_d;
            pwm_out       <= pwm_en & duty_hit(count, duty_eff);
            period_done   <= wrap;
        end
    end

`ifdef COUNT_PWM_IRQ_EN
    // Sticky interrupt.  The set term is tested first so a clear issued in
    // the same cycle as a period_done pulse cannot lose that event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (period_done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule
